// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: field positions, NOP encoding and the
// occupancy encoding used by every stage register in the core.
package pipe_stage_reg_pkg;

    localparam int FLD_INST = 0;
    localparam int FLD_PC   = 1;
    localparam int FLD_ALU  = 2;
    localparam int FLD_DATA = 3;

    // A zeroed instruction word is the NOP, so flushing to zero yields bubbles.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    // Entries lost to a flush: everything held, minus a head that left that cycle.
    function automatic logic [1:0] flush_drop(input occ_state_e s, input logic out_fire);
        logic [1:0] held;
        held = s;
        return held - {1'b0, out_fire};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with a 0..2 increment; never wraps past all-ones.
module pipe_stage_reg_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W:0] sum;

    always_comb begin
        sum = (CNT_W+1)'(count) + (CNT_W+1)'(inc);
    end

    // A carry out means the sum passed the maximum, even when inc is 2.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (sum[CNT_W]) begin
            count <= CNT_MAX;
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage with a two-entry skid buffer,
// flush-to-zero and a saturating count of entries discarded by flush.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic [1:0]                   occupancy,
    output logic [CNT_W-1:0]             drop_count
);

    localparam int ENTRY_W = NUM_FIELDS * DATA_W;

    occ_state_e         state;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;
    logic               in_fire;
    logic               out_fire;
    logic [1:0]         drop_inc;

    assign in_ready  = (state != OCC_TWO) && !flush && !rst;
    assign out_valid = (state != OCC_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // main always holds the head; skid only ever feeds main, keeping FIFO order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state  <= OCC_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        state  <= OCC_ONE;
                        main_q <= in_data;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state  <= OCC_TWO;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        state  <= OCC_EMPTY;
                        main_q <= '0;
                    end
                end
                OCC_TWO: begin
                    if (out_fire) begin
                        state  <= OCC_ONE;
                        main_q <= skid_q;
                        skid_q <= '0;
                    end
                end
                default: begin
                    state  <= OCC_EMPTY;
                    main_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        drop_inc = 2'd0;
        if (flush && !rst) begin
            drop_inc = flush_drop(state, out_fire);
        end
    end

    pipe_stage_reg_sat_counter #(
        .CNT_W (CNT_W)
    ) u_drop_counter (
        .clk   (clk),
        .clear (rst),
        .inc   (drop_inc),
        .count (drop_count)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic, all
// compared against a queue-based model; a CNT_W=2 copy exercises saturation.
module tb_pipe_stage_reg;

    localparam int DATA_W     = 32;
    localparam int NUM_FIELDS = 4;
    localparam int CNT_W      = 16;
    localparam int SAT_W      = 2;
    localparam int ENTRY_W    = DATA_W * NUM_FIELDS;
    localparam int MAX16      = (1 << CNT_W) - 1;
    localparam int MAX2       = (1 << SAT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               out_ready;
    logic [ENTRY_W-1:0] in_data;

    logic               in_ready,  sat_in_ready;
    logic               out_valid, sat_out_valid;
    logic [ENTRY_W-1:0] out_data,  sat_out_data;
    logic [1:0]         occupancy, sat_occupancy;
    logic [CNT_W-1:0]   drop_count;
    logic [SAT_W-1:0]   sat_drop_count;

    int errors = 0;
    int checks = 0;

    logic [ENTRY_W-1:0] model_q[$];
    int                 model_drop;
    int                 model_drop_sat;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
        .occupancy(sat_occupancy), .drop_count(sat_drop_count)
    );

    function automatic logic [ENTRY_W-1:0] mk(input logic [31:0] inst, input logic [31:0] pc,
                                              input logic [31:0] alu, input logic [31:0] data);
        return {data, alu, pc, inst};
    endfunction

    task automatic checkOutput(input string tag, input logic [ENTRY_W-1:0] actual,
                               input logic [ENTRY_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One cycle: drive inputs, compare against the model, then advance the model.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [ENTRY_W-1:0] d, input logic ordy);
        int                 n;
        logic               exp_ready;
        logic               in_fire;
        logic               out_fire;
        int                 dropped;
        logic [ENTRY_W-1:0] exp_data;
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        n         = model_q.size();
        exp_ready = (n < 2) && !f && !r;
        exp_data  = (n > 0) ? model_q[0] : '0;
        checkOutput("in_ready",      ENTRY_W'(in_ready),       ENTRY_W'(exp_ready));
        checkOutput("out_valid",     ENTRY_W'(out_valid),      ENTRY_W'(n > 0));
        checkOutput("out_data",      out_data,                 exp_data);
        checkOutput("occupancy",     ENTRY_W'(occupancy),      ENTRY_W'(n));
        checkOutput("drop_count",    ENTRY_W'(drop_count),     ENTRY_W'(model_drop));
        checkOutput("sat_drop",      ENTRY_W'(sat_drop_count), ENTRY_W'(model_drop_sat));
        checkOutput("sat_out_data",  sat_out_data,             exp_data);
        in_fire  = iv && exp_ready;
        out_fire = (n > 0) && ordy;
        if (r) begin
            model_q.delete();
            model_drop     = 0;
            model_drop_sat = 0;
        end else if (f) begin
            dropped        = n - (out_fire ? 1 : 0);
            model_drop     = (model_drop + dropped > MAX16) ? MAX16 : model_drop + dropped;
            model_drop_sat = (model_drop_sat + dropped > MAX2) ? MAX2 : model_drop_sat + dropped;
            model_q.delete();
        end else begin
            if (out_fire) void'(model_q.pop_front());
            if (in_fire) model_q.push_back(d);
        end
        @(posedge clk);
    endtask

    task automatic fillTwo(input logic [31:0] pc0, input logic [31:0] pc1);
        applyStimulus(1'b0, 1'b0, 1'b1, mk(32'h13, pc0, 32'h1, 32'h2), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, mk(32'h13, pc1, 32'h3, 32'h4), 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_drop = 0; model_drop_sat = 0;
        @(posedge clk);

        // Reset with a live input; then release.
        applyStimulus(1'b1, 1'b0, 1'b1, mk(32'hDEADBEEF, 32'h100, 32'h5, 32'h6), 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, mk(32'hDEADBEEF, 32'h100, 32'h5, 32'h6), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Streaming at full rate.
        applyStimulus(1'b0, 1'b0, 1'b1, mk(32'h00A00093, 32'h4, 32'h10, 32'h0), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, mk(32'h00A00093, 32'h8, 32'h10, 32'h0), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, mk(32'h00A00093, 32'hC, 32'h10, 32'h0), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Backpressure: third push refused, then drain in order.
        fillTwo(32'h20, 32'h24);
        applyStimulus(1'b0, 1'b0, 1'b1, mk(32'h13, 32'h28, 32'h0, 32'h0), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Flush while full, without and with a downstream transfer.
        fillTwo(32'h30, 32'h34);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        #2;
        checkOutput("flush_full_drop16", ENTRY_W'(drop_count), ENTRY_W'(2));
        checkOutput("flush_full_drop2",  ENTRY_W'(sat_drop_count), ENTRY_W'(2));
        checkOutput("flush_full_data",   out_data, '0);
        fillTwo(32'h40, 32'h44);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        #2;
        checkOutput("flush_pop_drop16", ENTRY_W'(drop_count), ENTRY_W'(3));
        checkOutput("flush_pop_drop2",  ENTRY_W'(sat_drop_count), ENTRY_W'(3));
        fillTwo(32'h50, 32'h54);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        #2;
        checkOutput("sat_hold_drop16", ENTRY_W'(drop_count), ENTRY_W'(5));
        checkOutput("sat_hold_drop2",  ENTRY_W'(sat_drop_count), ENTRY_W'(3));

        // Flush against an incoming entry while empty.
        applyStimulus(1'b0, 1'b1, 1'b1, mk(32'h13, 32'h60, 32'h0, 32'h0), 1'b0);
        #2;
        checkOutput("flush_in_occ",  ENTRY_W'(occupancy), ENTRY_W'(0));
        checkOutput("flush_in_drop", ENTRY_W'(drop_count), ENTRY_W'(5));

        // Reset while full clears everything without counting drops.
        fillTwo(32'h70, 32'h74);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        #2;
        checkOutput("rst_full_occ",   ENTRY_W'(occupancy), ENTRY_W'(0));
        checkOutput("rst_full_drop",  ENTRY_W'(drop_count), ENTRY_W'(0));
        checkOutput("rst_full_drop2", ENTRY_W'(sat_drop_count), ENTRY_W'(0));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
                          $urandom_range(0, 1) == 1,
                          {$urandom, $urandom, $urandom, $urandom},
                          $urandom_range(0, 9) < 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register. Successor to the fixed per-stage latches (fetch/decode/execute/memory).
- Carries NUM_FIELDS words of DATA_W bits each (e.g. instruction, PC, ALU result, store data) through a valid/ready handshake with a 2-entry skid buffer.
- Supports flush-to-zero, where a zeroed instruction field is the NOP encoding, plus backpressure and a saturating count of entries discarded by flush.
- Instantiated once per pipeline boundary in the processor core.

Parameters:
- DATA_W, 32, width of one field
- NUM_FIELDS, 4, number of fields carried per entry
- CNT_W, 16, width of the flush-drop counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  discard all held entries; synchronous, highest priority after rst
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept; a transfer occurs when in_valid & in_ready
- in_data  input  NUM_FIELDS*DATA_W  packed fields; field k occupies bits [k*DATA_W +: DATA_W]
- out_valid  output  1  entry presented downstream
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid & out_ready
- out_data  output  NUM_FIELDS*DATA_W  packed fields of the head entry; all zero when out_valid=0
- occupancy  output  2  entries held: 0, 1 or 2
- drop_count  output  CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- Storage:
  - main register drives out_data.
  - skid register holds the second entry.
  - State is EMPTY, ONE or TWO; occupancy encodes 0, 1, 2.
- Reset (rst=1 at edge): state EMPTY, main=0, skid=0, drop_count=0. Consequently out_valid=0, out_data=0, occupancy=0.
  - in_ready is 0 while rst is high.
  - rst overrides flush and all handshakes; reset mid-transfer discards everything with no drop counting.
- in_ready = (state != TWO) & ~flush & ~rst. This is the only combinational path from flush/rst to in_ready.
- out_valid = (state != EMPTY). It is registered-state driven and has no combinational path from inputs.
- Transitions (no rst, no flush); in_fire and out_fire as defined in Ports:
  - EMPTY:
    - in_fire -> ONE, main<=in_data.
    - Otherwise stay EMPTY.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire only -> TWO, skid<=in_data.
    - out_fire only -> EMPTY, main<=0.
    - Otherwise hold.
  - TWO:
    - out_fire -> ONE, main<=skid, skid<=0.
    - Otherwise hold. in_ready=0.
- Latency: an entry accepted into EMPTY appears on out_data/out_valid the next cycle. Throughput is 1 entry/cycle when out_ready stays high.
- Ordering: strictly FIFO. The skid entry never bypasses main.
- Flush (flush=1, rst=0):
  - Next state is EMPTY; main<=0, skid<=0.
  - in_ready=0 that cycle, so no input is accepted.
  - A downstream transfer firing in the flush cycle (out_valid & out_ready) counts as completed.
  - drop_count += (number of held entries) − (1 if out_fire else 0).
- drop_count:
  - Unsigned, saturates at 2^CNT_W−1.
  - Never wraps, even when an increment of 2 would cross the maximum.
  - Cleared only by rst.
- Data is never altered in flight. Fields are stored and returned bit-exact.
- out_data when out_valid=0 is guaranteed zero, because main is cleared on the emptying dequeue, on flush and on reset.

Decomposition:
- Shared pipeline package holds:
  - the NOP/zero-instruction constant
  - field index constants (FLD_INST=0, FLD_PC=1, FLD_ALU=2, FLD_DATA=3)
  - the occupancy state encoding (EMPTY=0, ONE=1, TWO=2)
- Optional sub-module sat_counter (parameter CNT_W; inputs inc amount 0–2 and clear).
- The skid storage stays inline in pipe_stage_reg.

Test Plan:
- Reset and idle: assert rst for 2 cycles with in_valid=1 and in_data nonzero -> out_valid=0, out_data=0, occupancy=0, drop_count=0, in_ready=0 during rst. Release rst -> in_ready=1.
- Streaming: out_ready=1, feed fields {inst=0x00A00093, pc=0x4, alu=0x10, data=0x0} then pc=0x8, 0xC on consecutive cycles -> each appears one cycle later in order, occupancy stays 1, in_ready stays 1.
- Backpressure: out_ready=0, push pc=0x20 then pc=0x24 -> occupancy=2 and in_ready=0; a third push with pc=0x28 is not accepted. Raise out_ready -> out pc=0x20, then 0x24; in_ready returns high after the first pop.
- Flush while full: occupancy=2, out_ready=0, flush=1 for one cycle -> next cycle out_valid=0, out_data=0, occupancy=0, drop_count=2. Repeat with out_ready=1 in the flush cycle -> drop_count increases by 1, and the head entry counts as delivered.
- Flush vs input: flush=1 with in_valid=1 and state EMPTY -> in_ready=0, nothing captured, drop_count unchanged.
- Saturation: CNT_W=2; perform flushes of 2 entries each -> drop_count goes 0→2→3→3, never 0. rst mid-stream with occupancy=2 -> empty, drop_count=0.
